// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC register, program-memory req/ack fetch, IR handoff to decode.
// Optional breakpoint halt/resume enabled by defining FETCH_SEQUENCER_BREAKPOINT_EN.
module fetch_sequencer #(
  parameter int            AW       = 11,
  parameter int            IW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          exec_done,
  input  logic          jump_taken,
  input  logic [AW-1:0] jump_address,
  input  logic          halt,
`ifdef FETCH_SEQUENCER_BREAKPOINT_EN
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
`endif
  output logic [AW-1:0] pc,
  output logic          halted
);

  typedef enum logic [2:0] {
    FETCH_ISSUE,
    FETCH_WAIT,
    DECODE,
    EXECUTE,
    HALTED
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          bp_halt_q, bp_halt_d;
  logic          req;
  logic          bp_hit;
  logic          bp_release;

`ifdef FETCH_SEQUENCER_BREAKPOINT_EN
  assign bp_hit     = bp_en && (pc_q == bp_addr);
  assign bp_release = bp_halt_q && !bp_en;
`else
  // bp_halt_q never sets without the breakpoint hardware, so this is always 0.
  assign bp_hit     = 1'b0;
  assign bp_release = bp_halt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH_ISSUE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      bp_halt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      bp_halt_q <= bp_halt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    bp_halt_d = bp_halt_q;
    req       = 1'b0;
    case (state_q)
      FETCH_ISSUE: begin
        if (bp_hit) begin
          state_d   = HALTED;
          bp_halt_d = 1'b1;
        end else begin
          req     = 1'b1;
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        req = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (ir_ready) state_d = EXECUTE;
      end
      EXECUTE: begin
        if (exec_done) begin
          pc_d    = jump_taken ? jump_address : pc_q + AW'(1);
          state_d = halt ? HALTED : FETCH_ISSUE;
        end
      end
      HALTED: begin
        if (bp_release) begin
          state_d   = FETCH_ISSUE;
          bp_halt_d = 1'b0;
        end
      end
      default: state_d = FETCH_ISSUE;
    endcase
  end

  // Reset parks the FSM in FETCH_ISSUE, so gate with rst to drop a request immediately.
  assign mem_req  = req & ~rst;
  assign mem_addr = pc_q;
  assign ir       = ir_q;
  assign ir_valid = (state_q == DECODE);
  assign halted   = (state_q == HALTED);
  assign pc       = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: scoreboard of expected fetch addresses checked on each request.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [10:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        exec_done;
  logic        jump_taken;
  logic [10:0] jump_address;
  logic        halt;
  logic [10:0] pc;
  logic        halted;
`ifdef FETCH_SEQUENCER_BREAKPOINT_EN
  logic        bp_en;
  logic [10:0] bp_addr;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];

  fetch_sequencer #(.AW(11), .IW(16), .RESET_PC(11'd0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .exec_done(exec_done), .jump_taken(jump_taken), .jump_address(jump_address), .halt(halt),
`ifdef FETCH_SEQUENCER_BREAKPOINT_EN
    .bp_en(bp_en), .bp_addr(bp_addr),
`endif
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [10:0] a);
    return {a, 5'b10110} ^ 16'h3C3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_addr(output logic [10:0] a);
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_bad++;
      $error("FAIL sb_empty: observed fetch at %0h expected none", mem_addr);
    end
    a = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7FF;
  endtask

  // Entered at a falling edge with the DUT in FETCH_ISSUE; leaves at falling edge + 1.
  task automatic do_instr(input int ack_dly, input int rdy_dly, input bit late_ack,
                          input bit jt, input logic [10:0] ja, input bit hlt);
    logic [10:0] a;
    logic [10:0] nxt;
    #1;
    pop_addr(a);
    chk("issue_req", mem_req, 1'b1);
    chk("issue_addr", mem_addr, a);
    if (late_ack) begin
      mem_ack = 1'b1;
      mem_rdata = 16'hDEAD;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      #1;
      chk("wait_req", mem_req, 1'b1);
      chk("wait_addr", mem_addr, a);
      chk("wait_irv", ir_valid, 1'b0);
      @(negedge clk);
    end
    mem_ack = 1'b1;
    mem_rdata = memf(a);
    #1;
    chk("ack_req", mem_req, 1'b1);
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    #1;
    chk("dec_irv", ir_valid, 1'b1);
    chk("dec_ir", ir, memf(a));
    chk("dec_req", mem_req, 1'b0);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      #1;
      chk("stall_irv", ir_valid, 1'b1);
      chk("stall_ir", ir, memf(a));
    end
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    #1;
    chk("exe_irv", ir_valid, 1'b0);
    chk("exe_pc", pc, a);
    nxt = jt ? ja : a + 11'd1;
    exec_done = 1'b1;
    jump_taken = jt;
    jump_address = ja;
    halt = hlt;
    @(negedge clk);
    exec_done = 1'b0;
    jump_taken = 1'b0;
    halt = 1'b0;
    #1;
    chk("next_pc", pc, nxt);
    chk("halted", halted, hlt);
    if (hlt) chk("halt_req", mem_req, 1'b0);
    else exp_q.push_back(nxt);
  endtask

  initial begin
    logic [10:0] a;
    rst = 1'b1;
    mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
    exec_done = 1'b0; jump_taken = 1'b0; jump_address = '0; halt = 1'b0;
`ifdef FETCH_SEQUENCER_BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = '0;
`endif
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_pc", pc, 11'd0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_irv", ir_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(11'd0);

    // sequential run, then jumps, wrap, stalls
    do_instr(0, 0, 0, 0, 11'h0, 0);
    do_instr(0, 0, 0, 0, 11'h0, 0);
    do_instr(0, 0, 0, 0, 11'h0, 0);
    do_instr(0, 0, 0, 1, 11'd5, 0);
    do_instr(0, 0, 0, 1, 11'h12A, 0);
    do_instr(0, 0, 0, 1, 11'd5, 0);
    do_instr(0, 0, 0, 0, 11'h3FF, 0);
    do_instr(5, 4, 0, 1, 11'd2047, 0);
    do_instr(0, 0, 0, 0, 11'h0, 0);
    do_instr(0, 0, 0, 1, 11'd9, 0);
    do_instr(0, 0, 0, 0, 11'h0, 1);

    // stray inputs while halted
    for (int i = 0; i < 6; i++) begin
      exec_done = 1'b1; jump_taken = i[0]; jump_address = 11'h55;
      mem_ack = 1'b1; mem_rdata = 16'hBEEF; ir_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("hlt_pc", pc, 11'd10);
      chk("hlt_flag", halted, 1'b1);
      chk("hlt_req", mem_req, 1'b0);
      chk("hlt_irv", ir_valid, 1'b0);
    end
    exec_done = 1'b0; jump_taken = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;

    // reset out of HALTED
    rst = 1'b1;
    #1;
    chk("rst2_halted", halted, 1'b0);
    chk("rst2_pc", pc, 11'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(11'd0);
    do_instr(0, 0, 0, 1, 11'd7, 0);

    // async reset while in FETCH_WAIT
    #1;
    pop_addr(a);
    chk("mid_addr", mem_addr, a);
    @(negedge clk);
    #2;
    chk("mid_wait_req", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_pc", pc, 11'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(11'd0);
    do_instr(1, 0, 1, 0, 11'h0, 0);
    do_instr(0, 0, 0, 0, 11'h0, 0);

`ifdef FETCH_SEQUENCER_BREAKPOINT_EN
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    bp_en = 1'b1;
    bp_addr = 11'd3;
    exp_q.delete();
    exp_q.push_back(11'd0);
    do_instr(0, 0, 0, 0, 11'h0, 0);
    do_instr(0, 0, 0, 0, 11'h0, 0);
    do_instr(0, 0, 0, 0, 11'h0, 0);
    #1;
    chk("bp_noreq", mem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("bp_halted", halted, 1'b1);
      chk("bp_pc", pc, 11'd3);
      chk("bp_req", mem_req, 1'b0);
    end
    bp_en = 1'b0;
    @(negedge clk);
    do_instr(0, 0, 0, 0, 11'h0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Holds the 11-bit program counter and runs instruction fetch from program memory through a req/ack handshake.
- Presents each fetched instruction word to decode with a valid/ready handshake.
- After execute completes, loads the next PC:
  - the branch unit's jump target when a jump is taken;
  - otherwise PC+1.
- Sits directly downstream of the branch-target unit: it consumes jump_address and jump_taken and produces the PC that unit adds to.

Parameters:
- AW, 11, PC / program-memory address width.
- IW, 16, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  fetch request to program memory.
- mem_addr  out  AW  fetch address; equals pc while mem_req=1.
- mem_ack  in  1  memory has driven mem_rdata this cycle.
- mem_rdata  in  IW  instruction word.
- ir  out  IW  latched instruction register.
- ir_valid  out  1  ir holds an instruction not yet accepted by decode.
- ir_ready  in  1  decode accepts ir.
- exec_done  in  1  one-cycle pulse: current instruction finished.
- jump_taken  in  1  sampled with exec_done; 1 means load jump_address.
- jump_address  in  AW  branch target; already resolved by the branch unit, either PC+offset or PC+1.
- halt  in  1  sampled with exec_done; stop after this instruction.
- pc  out  AW  current PC, fed to the branch unit.
- halted  out  1  sequencer is stopped.

Behaviour:
- Reset (async, immediate) sets every output and internal register:
  - pc=RESET_PC, ir=0, mem_req=0, ir_valid=0, halted=0;
  - state=FETCH_ISSUE.
  - An outstanding request is abandoned; mem_req drops in the same instant.
- State FETCH_ISSUE:
  - drive mem_req=1, mem_addr=pc;
  - next cycle → FETCH_WAIT.
- State FETCH_WAIT:
  - hold mem_req=1 and mem_addr until mem_ack=1;
  - on ack, ir<=mem_rdata, mem_req<=0, ir_valid<=1 → DECODE.
  - Fetch latency is 2 cycles minimum when ack arrives in the first FETCH_WAIT cycle; there is no timeout.
- State DECODE:
  - hold ir and ir_valid=1 until ir_ready=1;
  - on ir_valid&ir_ready, ir_valid<=0 → EXECUTE.
  - ir must not change while ir_valid=1.
- State EXECUTE: wait for exec_done.
  - pc<= jump_taken ? jump_address : pc+1, modulo 2^AW (2047+1 wraps to 0).
  - halt=1 with exec_done: pc still updates, then → HALTED.
  - Otherwise → FETCH_ISSUE.
- State HALTED:
  - halted=1, mem_req=0, ir_valid=0;
  - all inputs ignored; only rst exits.
- Ignored inputs:
  - mem_ack outside FETCH_WAIT is ignored.
  - exec_done outside EXECUTE is ignored, and jump_taken/halt with it.
  - ir_ready outside DECODE has no effect.
- pc changes only on exec_done in EXECUTE, or on reset.
- No prefetch: exactly one instruction is in flight.

Optional Feature:
- Macro: FETCH_SEQUENCER_BREAKPOINT_EN.
- Enabled adds two inputs: bp_en (1) and bp_addr (AW).
- Breakpoint check:
  - In FETCH_ISSUE with bp_en=1 and pc==bp_addr, no request is issued (mem_req stays 0).
  - The block goes to HALTED with halted=1 and pc unchanged.
- Resume: deasserting bp_en while in HALTED returns to FETCH_ISSUE at the same pc. Only breakpoint-caused halts resume; halt-input halts still need rst.
- Disabled: ports absent, behaviour exactly as above.

Test Plan:
- Reset then sequential run:
  - RESET_PC=0, memory returns ack one cycle after req, ir_ready=1, exec_done pulses with jump_taken=0;
  - mem_addr sequence 0,1,2,3; ir follows memory contents; mem_req high exactly 2 cycles per fetch.
- Taken jump:
  - at pc=5, exec_done with jump_taken=1, jump_address=0x12A;
  - next mem_addr=0x12A, pc=0x12A.
  - Not-taken at pc=5 gives next fetch at 6.
- Wrap and stalls:
  - pc=2047, exec_done, jump_taken=0 → pc=0.
  - mem_ack delayed 5 cycles: mem_req and mem_addr stable throughout.
  - ir_ready held low 4 cycles: ir_valid stays 1 with ir constant.
- Halt:
  - exec_done with halt=1 at pc=9 → pc=10, halted=1, mem_req=0 permanently.
  - Stray exec_done/mem_ack afterwards change nothing.
- Async reset mid-fetch:
  - assert rst in FETCH_WAIT between clock edges → mem_req=0 and pc=RESET_PC before the next edge.
  - A late mem_ack after release is ignored; the next fetch starts at RESET_PC.
- (BREAKPOINT_EN) bp_en=1, bp_addr=3 on a sequential run:
  - fetches 0,1,2 complete; halted=1 at pc=3 with no request at 3;
  - clearing bp_en resumes with fetch at 3.
